// File: rtl/multicycle_control.sv
// Main controller for a multicycle RV32 subset core (lw, sw, R/I ALU ops, beq, jal).
// Moore FSM: outputs decode from the current state, with mem_ready/zero only where noted.
`timescale 1ns/1ps
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic       illegal,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    state_t state_q, state_d;
    logic   r_legal, i_legal;
    logic   fetch_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        r_legal = ({funct7b5, funct3} == 4'b0000) || ({funct7b5, funct3} == 4'b1000) ||
                  ({funct7b5, funct3} == 4'b0111) || ({funct7b5, funct3} == 4'b0110);
        i_legal = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
        // State already reads FETCH during reset; only its strobes need masking.
        fetch_go = mem_ready & ~reset;
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        adr_src     = 1'b0;
        illegal     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = fetch_go;
                pc_write   = fetch_go;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = r_legal ? S_EXECUTER : S_ILLEGAL;
                    OP_I:         state_d = i_legal ? S_EXECUTEI : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                case (funct3)
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    // Immediate form has no SUB; funct7b5 there is immediate bits.
                    default: alu_control = (funct7b5 && state_q == S_EXECUTER) ? ALU_SUB : ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences built from the
// instruction-level behaviour, compared every cycle, with random waits, opcodes and resets.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src), .illegal(illegal),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] AND_C = 4'b0000;
    localparam logic [3:0] OR_C  = 4'b0001;
    localparam logic [3:0] ADD_C = 4'b0010;
    localparam logic [3:0] SUB_C = 4'b0110;

    // {pc_write, ir_write, mem_write, reg_write, adr_src, illegal, result_src, src_a, src_b, alu}
    logic [17:0] obs;
    assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, illegal,
                  result_src, alu_src_a, alu_src_b, alu_control};

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    logic        mr_q[$];
    logic        z_q[$];
    string       tag_q[$];

    function automatic logic [17:0] v(input logic pcw, input logic irw, input logic mw,
                                      input logic rw, input logic adr, input logic ill,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [3:0] alu);
        return {pcw, irw, mw, rw, adr, ill, rs, sa, sb, alu};
    endfunction

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic mr, input logic z, input logic [17:0] e, input string tag);
        mr_q.push_back(mr);
        z_q.push_back(z);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1: apply inputs, check at negedge, return at next posedge+1.
    task automatic cyc(input logic mr, input logic z, input logic [17:0] e, input string tag);
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
        chk(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    // 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (op)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b000) &&
                               !(f7 && f3 != 3'b000) ? 2 : 6;
            7'b0010011: return (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b000) ? 3 : 6;
            7'b1100011: return 4;
            7'b1101111: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
        if (f3 == 3'b111) return AND_C;
        if (f3 == 3'b110) return OR_C;
        return sub ? SUB_C : ADD_C;
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int wf, input int wm, input logic z, input bit abort_sw,
                             output bit stuck);
        int cls;
        logic [17:0] wb_v;
        cls      = classify(op, f3, f7);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        wb_v     = v(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD_C);
        for (int i = 0; i < wf; i++) push(0, rb(), v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C), "fetch_wait");
        push(1, rb(), v(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C), "fetch");
        push(rb(), rb(), v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD_C), "decode");
        stuck = 0;
        case (cls)
            0: begin
                push(rb(), rb(), v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD_C), "lw_adr");
                for (int i = 0; i < wm; i++) push(0, rb(), v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD_C), "lw_rd_wait");
                push(1, rb(), v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD_C), "lw_rd");
                push(rb(), rb(), v(0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, ADD_C), "lw_wb");
            end
            1: begin
                push(rb(), rb(), v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD_C), "sw_adr");
                for (int i = 0; i < wm; i++) push(0, rb(), v(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD_C), "sw_wait");
                if (abort_sw) begin
                    if (wm == 0) push(0, rb(), v(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD_C), "sw_wait");
                    stuck = 1;
                end else begin
                    push(1, rb(), v(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD_C), "sw_done");
                end
            end
            2: begin
                push(rb(), rb(), v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7)), "exec_r");
                push(rb(), rb(), wb_v, "alu_wb");
            end
            3: begin
                push(rb(), rb(), v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0)), "exec_i");
                push(rb(), rb(), wb_v, "alu_wb");
            end
            4: push(rb(), z, v(z, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, SUB_C), "beq");
            5: begin
                push(rb(), rb(), v(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD_C), "jal");
                push(rb(), rb(), wb_v, "jal_wb");
            end
            default: begin
                for (int i = 0; i < 12; i++) push(rb(), rb(), v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD_C), "illegal");
                stuck = 1;
            end
        endcase
        while (exp_q.size() > 0)
            cyc(mr_q.pop_front(), z_q.pop_front(), exp_q.pop_front(), tag_q.pop_front());
    endtask

    // Called at posedge+1; leaves the DUT in FETCH at posedge+1 after one idle edge.
    task automatic pulse_reset();
        mem_ready = 1'b1;
        #1 reset = 1'b1;
        #1 chk("rst_async", obs, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C));
        @(negedge clk);
        chk("rst_hold", obs, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C));
        #1 reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 chk("post_rst", obs, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C));
    endtask

    logic [6:0] op_tab[8];
    bit         stuck;

    initial begin
        op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                   7'b1100011, 7'b1101111, 7'b0110011, 7'b0010011};
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        @(negedge clk);
        chk("reset_state", obs, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C));
        @(negedge clk);
        chk("reset_state2", obs, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD_C));
        #1 reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, 0, stuck);   // sub
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0, 0, stuck);   // lw, 2 waits
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 0, stuck);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, 0, stuck);   // beq not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0, 0, stuck);   // jal
        run_instr(7'b0100011, 3'b010, 1'b0, 2, 1, 1'b0, 0, stuck);   // sw, waits
        run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, 0, stuck);   // addi, funct7b5 ignored
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 0, stuck);
        if (stuck) pulse_reset();
        run_instr(7'b0010011, 3'b001, 1'b0, 0, 0, 1'b0, 0, stuck);
        if (stuck) pulse_reset();
        run_instr(7'b0110011, 3'b111, 1'b1, 0, 0, 1'b0, 0, stuck);   // bad R encoding
        if (stuck) pulse_reset();
        run_instr(7'b0100011, 3'b010, 1'b0, 1, 2, 1'b0, 1, stuck);   // sw aborted
        if (stuck) pulse_reset();

        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int         k;
            k  = int'($urandom_range(0, 8));
            op = (k == 8) ? 7'($urandom) : op_tab[k];
            case ($urandom_range(0, 3))
                0:       f3 = 3'b000;
                1:       f3 = 3'b111;
                2:       f3 = 3'b110;
                default: f3 = 3'($urandom);
            endcase
            run_instr(op, f3, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      rb(), ($urandom_range(0, 9) == 0), stuck);
            if (stuck) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
